link_tx: RTL and testbench
==========================

Name: link_tx

Overview:
- Serial transmitter that sends the local player's game status to the opponent board over one wire.
- Payload per frame: CHECK result, HP and CONTROL state. The opponent's link receiver feeds it into WIN_LOSE/CONTROL as the remote side.
- Sits beside CHECK/CONTROL in the top level; TXD drives a GPIO pin.
- Fixed UART-like frame with even parity, plus a one-deep pending buffer so back-to-back updates are not lost.

Parameters:
- BIT_CYCLES, 5000, clock cycles per serial bit (50 MHz / 10 kbit/s); legal range 2..65535.
- DATA_BITS, 8, payload width; fixed by frame format, not overridable in practice.

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous, active-high reset
- SEND  input  1  single-cycle request: transmit current payload
- RESULT  input  2  CHECK result code
- HP  input  2  remaining hit points
- STATE  input  4  CONTROL state code
- TXD  output  1  serial line, idle high
- BUSY  output  1  high while a frame is on the line
- DONE  output  1  one-cycle pulse when a frame's stop bit completes
- OVERRUN  output  1  one-cycle pulse when a pending payload is overwritten

Behaviour:
- Reset state (asynchronous, takes effect immediately): TXD=1, BUSY=0, DONE=0, OVERRUN=0, FSM=IDLE, bit counter=0, pending=0.
- Payload byte is {STATE, HP, RESULT}, sent LSB first (RESULT[0] first).
- Frame:
  - start bit = 0
  - 8 data bits
  - parity bit = XOR of the 8 data bits (even parity)
  - stop bit = 1
  - Each bit lasts exactly BIT_CYCLES cycles; a frame is 11*BIT_CYCLES cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when SEND=1 at edge k, latch the payload into the shift register. At edge k+1 enter START; TXD=0 and BUSY=1 from that edge.
  - START -> DATA after BIT_CYCLES cycles.
  - DATA: shift one bit per BIT_CYCLES cycles. A 3-bit index counts 0..7; after index 7's period, go to PARITY.
  - PARITY -> STOP after BIT_CYCLES cycles.
  - STOP: at the end of the period, DONE pulses for one cycle.
    - If pending=1, load the pending payload, clear pending and go directly to START on the same edge; BUSY stays 1 and there is no idle gap.
    - Otherwise go to IDLE with BUSY=0.
- Baud counter:
  - Counts 0..BIT_CYCLES-1 and reloads to 0 on every bit transition.
  - Held at 0 in IDLE.
  - Width is clog2(BIT_CYCLES).
- SEND while BUSY=1:
  - Latch the payload into the pending register and set pending=1.
  - If pending was already 1, overwrite it (newest wins) and pulse OVERRUN for one cycle.
- SEND on the same edge as the STOP-end transition:
  - If pending=0, the new payload starts immediately as the next frame.
  - If pending=1, the pending payload is sent and the new one becomes pending; OVERRUN is not pulsed.
- Inputs are sampled only on the SEND edge. Later input changes do not alter a frame in flight.
- Reset mid-frame aborts the frame: TXD returns to 1 at once and pending is cleared.
- TXD and all outputs are registered (no combinational path from inputs).

Decomposition:
- Package link_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - START_BIT=0, STOP_BIT=1, FRAME_BITS=11
  - payload field offsets (RESULT 1:0, HP 3:2, STATE 7:4), shared with the future link_rx
- Sub-module baud_tick: parameterised counter with clear input and tick output. It is reused by link_rx at half-bit offset.

Test Plan (BIT_CYCLES=4):
- Reset, then SEND with RESULT=2'b01, HP=2'b11, STATE=4'h5:
  - payload 0x5D
  - TXD sequence per 4 cycles: 0, 1,0,1,1,1,0,1,0, parity 1, stop 1
  - DONE pulses at cycle 44 after accept; BUSY low the next cycle
- Payload 0x00 (all zero):
  - parity bit 0
  - frame = 0, eight 0s, 0, 1
  - total low time 40 cycles
- SEND at cycle 10 of a frame with payload 0xA3:
  - pending set
  - second frame starts on the cycle after the first stop ends, with no idle high beyond the stop bit
  - BUSY stays high for 88 cycles
- Two SENDs during one frame (0x11, then 0x22):
  - OVERRUN pulses once on the second SEND
  - next frame carries 0x22
- Assert RST during the DATA phase:
  - TXD=1, BUSY=0 immediately (asynchronous)
  - after release, SEND produces a complete, correct frame
- Change RESULT/HP/STATE every cycle during a frame:
  - transmitted bits match the value latched at the SEND edge

Source files
------------

// File: rtl/link_pkg.sv
// Shared definitions for the board-to-board status link: FSM states, frame constants
// and payload field layout, common to the transmitter and the future receiver.
package link_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} link_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 11;

  localparam int PAYLOAD_W  = 8;
  localparam int RESULT_LSB = 0;
  localparam int RESULT_W   = 2;
  localparam int HP_LSB     = 2;
  localparam int HP_W       = 2;
  localparam int STATE_LSB  = 4;
  localparam int STATE_W    = 4;

  function automatic logic [PAYLOAD_W-1:0] pack_payload(
    input logic [RESULT_W-1:0] result,
    input logic [HP_W-1:0]     hp,
    input logic [STATE_W-1:0]  ctrl
  );
    logic [PAYLOAD_W-1:0] p;
    p = '0;
    p[RESULT_LSB +: RESULT_W] = result;
    p[HP_LSB +: HP_W]         = hp;
    p[STATE_LSB +: STATE_W]   = ctrl;
    return p;
  endfunction

endpackage

// File: rtl/link_tx_baud_tick.sv
// Bit-period counter: counts 0..CYCLES-1 and wraps, tick marks the last count of a period.
// Held at zero while clr is high, so the first period after clr drops is a full one.
module baud_tick #(
  parameter  int unsigned CYCLES = 5000,
  localparam int unsigned W      = $clog2(CYCLES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tick
);

  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/link_tx.sv
// Serial status transmitter: start, payload LSB first, even parity, stop, idle-high line.
// One-deep pending buffer lets a new SEND ride behind the frame on the line (newest wins).
module link_tx
  import link_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 5000,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SEND,
  input  logic [1:0] RESULT,
  input  logic [1:0] HP,
  input  logic [3:0] STATE,
  output logic       TXD,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVERRUN
);

  localparam int unsigned      CNT_W    = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] DONE_AT  = CNT_W'(BIT_CYCLES - 2);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  link_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] pend_dat_q, pend_dat_d;
  logic [2:0]           idx_q, idx_d;
  logic                 par_q, par_d;
  logic                 pend_q, pend_d;
  logic                 launch_q, launch_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;

  logic [CNT_W-1:0]     cnt;
  logic                 tick;
  logic                 frame_end;
  logic [DATA_BITS-1:0] payload;

  assign payload   = DATA_BITS'(pack_payload(RESULT, HP, STATE));
  assign frame_end = (state_q == STOP) && tick;

  baud_tick #(.CYCLES(BIT_CYCLES)) u_baud (
    .clk  (CLK),
    .rst  (RST),
    .clr  (state_q == IDLE),
    .cnt  (cnt),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    pend_dat_d = pend_dat_q;
    launch_d   = 1'b0;
    ovr_d      = 1'b0;
    // Registered DONE must be raised one count early to land on the stop bit's last cycle.
    done_d     = (state_q == STOP) && (cnt == DONE_AT);

    case (state_q)
      IDLE:   if (launch_q) state_d = START;
      START:  if (tick) begin
                state_d = DATA;
                idx_d   = '0;
              end
      DATA:   if (tick) begin
                shreg_d = shreg_q >> 1;
                if (idx_q == IDX_LAST) state_d = PARITY;
                else                   idx_d   = idx_q + 3'd1;
              end
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick) begin
                if (pend_q) begin
                  shreg_d = pend_dat_q;
                  par_d   = ^pend_dat_q;
                  pend_d  = 1'b0;
                  state_d = START;
                end else begin
                  state_d = IDLE;
                end
              end
      default: state_d = IDLE;
    endcase

    if (SEND) begin
      if (state_q == IDLE && !launch_q) begin
        shreg_d  = payload;
        par_d    = ^payload;
        launch_d = 1'b1;
      end else if (frame_end && !pend_q) begin
        shreg_d = payload;
        par_d   = ^payload;
        state_d = START;
      end else begin
        // A pending payload drained on this same edge is not an overrun.
        ovr_d      = pend_q && !frame_end;
        pend_d     = 1'b1;
        pend_dat_d = payload;
      end
    end

    case (state_d)
      START:   txd_d = START_BIT;
      DATA:    txd_d = shreg_d[0];
      PARITY:  txd_d = par_d;
      default: txd_d = STOP_BIT;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      pend_dat_q <= '0;
      idx_q      <= '0;
      par_q      <= 1'b0;
      pend_q     <= 1'b0;
      launch_q   <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      pend_dat_q <= pend_dat_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      pend_q     <= pend_d;
      launch_q   <= launch_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  assign TXD     = txd_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_link_tx.sv
// Bench for link_tx: hand-computed frame vectors, multi-cycle corner sequences and random
// traffic, all checked cycle by cycle against a frame-timeline reference model.
module tb_link_tx;
  import link_pkg::*;

  localparam int BC        = 4;
  localparam int FRAME_CYC = FRAME_BITS * BC;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SEND;
  logic [1:0] RESULT, HP;
  logic [3:0] STATE;
  logic       TXD, BUSY, DONE, OVERRUN;

  link_tx #(.BIT_CYCLES(BC), .DATA_BITS(8)) dut (
    .CLK(CLK), .RST(RST), .SEND(SEND), .RESULT(RESULT), .HP(HP), .STATE(STATE),
    .TXD(TXD), .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: one frame on the line (start edge + byte) and a single pending slot.
  bit         m_busy, m_pv, m_ovr;
  int         m_start;
  logic [7:0] m_byte, m_pb;
  logic [7:0] exp_q[$];

  // Line decoder state.
  int          dpos = -1;
  logic [10:0] dbits;
  logic [7:0]  last_rx;
  logic [7:0]  rx_hist[$];

  typedef struct {
    logic [1:0] r;
    logic [1:0] h;
    logic [3:0] s;
    logic [7:0] byt_e;
    logic       par_e;
    int         low_e;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [7:0] p;
    bit ended;
    p     = {STATE, HP, RESULT};
    m_ovr = 1'b0;
    if (RST) begin
      m_busy = 1'b0;
      m_pv   = 1'b0;
      exp_q.delete();
      return;
    end
    ended = m_busy && (cyc == m_start + FRAME_CYC);
    if (ended) begin
      if (m_pv) begin
        m_start = cyc;
        m_byte  = m_pb;
        m_pv    = 1'b0;
        exp_q.push_back(m_pb);
      end else begin
        m_busy = 1'b0;
      end
    end
    if (SEND) begin
      if (!m_busy) begin
        m_busy  = 1'b1;
        m_start = ended ? cyc : cyc + 1;
        m_byte  = p;
        exp_q.push_back(p);
      end else begin
        m_ovr = m_pv;
        m_pv  = 1'b1;
        m_pb  = p;
      end
    end
  endtask

  function automatic logic [3:0] model_out();
    int   o;
    logic txd;
    if (!m_busy || cyc < m_start) return {1'b1, 1'b0, 1'b0, m_ovr};
    o = cyc - m_start;
    case (o / BC)
      0:       txd = 1'b0;
      9:       txd = ^m_byte;
      10:      txd = 1'b1;
      default: txd = m_byte[o / BC - 1];
    endcase
    return {txd, 1'b1, (o == FRAME_CYC - 1), m_ovr};
  endfunction

  task automatic decode();
    if (RST) begin
      dpos = -1;
      return;
    end
    if (dpos < 0) begin
      if (TXD === 1'b0) dpos = 0;
    end else begin
      dpos++;
    end
    if (dpos >= 0 && dpos % BC == BC / 2) dbits[dpos / BC] = TXD;
    if (dpos == FRAME_CYC - 1) begin
      last_rx = dbits[8:1];
      rx_hist.push_back(last_rx);
      chk("frame_fmt", {29'd0, dbits[10], dbits[9] ^ (^dbits[8:1]), dbits[0]}, 32'd4);
      chk("rx_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("rx_byte", last_rx, exp_q.pop_front());
      dpos = -1;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    cyc++;
    model_edge();
    #1;
    chk("outputs", {TXD, BUSY, DONE, OVERRUN}, model_out());
    decode();
  endtask

  task automatic send(input logic [1:0] r, input logic [1:0] h, input logic [3:0] s);
    RESULT = r; HP = h; STATE = s; SEND = 1'b1;
    step();
    SEND = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      if (BUSY === 1'b0 && dpos < 0 && exp_q.size() == 0) break;
      step();
    end
    chk("idle_wait", (BUSY === 1'b0 && dpos < 0), 1);
  endtask

  initial begin
    int busy_cnt, busy_rise, ovr_cnt, ovr_at_second;
    logic prev_busy;

    tbl[0] = '{2'b01, 2'b11, 4'h5, 8'h5D, 1'b1, 16};
    tbl[1] = '{2'b00, 2'b00, 4'h0, 8'h00, 1'b0, 40};
    tbl[2] = '{2'b11, 2'b00, 4'hA, 8'hA3, 1'b0, 24};
    tbl[3] = '{2'b11, 2'b11, 4'hF, 8'hFF, 1'b0, 8};
    tbl[4] = '{2'b00, 2'b00, 4'h8, 8'h80, 1'b1, 32};

    RST = 1'b1; SEND = 1'b0; RESULT = '0; HP = '0; STATE = '0;
    #3;
    chk("reset_state", {TXD, BUSY, DONE, OVERRUN}, 4'b1000);
    repeat (3) step();
    RST = 1'b0;
    repeat (2) step();

    // Single frames from the vector table.
    for (int v = 0; v < 5; v++) begin
      int low_cnt, done_at, idle_at;
      wait_idle();
      rx_hist.delete();
      send(tbl[v].r, tbl[v].h, tbl[v].s);
      low_cnt = 0; done_at = -1; idle_at = -1;
      for (int o = 1; o <= 46; o++) begin
        step();
        if (TXD === 1'b0) low_cnt++;
        if (DONE === 1'b1 && done_at < 0) done_at = o;
        if (BUSY === 1'b0 && idle_at < 0) idle_at = o;
      end
      chk("vec_rx_count", rx_hist.size(), 1);
      chk("vec_byte", last_rx, tbl[v].byt_e);
      chk("vec_parity", dbits[9], tbl[v].par_e);
      chk("vec_low_cycles", low_cnt, tbl[v].low_e);
      chk("vec_done_cycle", done_at, 44);
      chk("vec_busy_drop", idle_at, 45);
    end

    // Second SEND ten cycles into a frame: queued, sent with no idle gap.
    wait_idle();
    rx_hist.delete();
    send(2'b01, 2'b11, 4'h5);
    busy_cnt = 0; busy_rise = 0; prev_busy = 1'b0;
    for (int i = 1; i <= 120; i++) begin
      if (i == 10) send(2'b11, 2'b00, 4'hA);
      else step();
      if (BUSY === 1'b1) busy_cnt++;
      if (BUSY === 1'b1 && prev_busy === 1'b0) busy_rise++;
      prev_busy = BUSY;
    end
    chk("b2b_busy_cycles", busy_cnt, 88);
    chk("b2b_busy_rises", busy_rise, 1);
    chk("b2b_rx_count", rx_hist.size(), 2);
    if (rx_hist.size() == 2) chk("b2b_second_byte", rx_hist[1], 8'hA3);

    // Two SENDs during one frame: newest wins, one OVERRUN pulse.
    wait_idle();
    rx_hist.delete();
    send(2'b01, 2'b11, 4'h5);
    ovr_cnt = 0; ovr_at_second = 0;
    for (int i = 1; i <= 120; i++) begin
      if (i == 5)       send(2'b01, 2'b00, 4'h1);
      else if (i == 15) send(2'b10, 2'b00, 4'h2);
      else              step();
      if (OVERRUN === 1'b1) ovr_cnt++;
      if (i == 15) ovr_at_second = OVERRUN;
    end
    chk("ovr_pulses", ovr_cnt, 1);
    chk("ovr_on_second_send", ovr_at_second, 1);
    chk("ovr_rx_count", rx_hist.size(), 2);
    if (rx_hist.size() == 2) chk("ovr_kept_newest", rx_hist[1], 8'h22);

    // Asynchronous reset in the middle of the data bits.
    wait_idle();
    send(2'b01, 2'b11, 4'h5);
    repeat (15) step();
    chk("pre_reset_busy", BUSY, 1);
    #2 RST = 1'b1;
    #1 chk("async_reset", {TXD, BUSY, DONE, OVERRUN}, 4'b1000);
    repeat (2) step();
    RST = 1'b0;
    rx_hist.delete();
    repeat (3) step();
    send(2'b00, 2'b11, 4'h3);
    repeat (50) step();
    chk("post_reset_rx_count", rx_hist.size(), 1);
    if (rx_hist.size() == 1) chk("post_reset_byte", rx_hist[0], 8'h3C);

    // Inputs churn every cycle while the frame is on the line.
    wait_idle();
    rx_hist.delete();
    send(2'b10, 2'b01, 4'h9);
    for (int i = 0; i < 50; i++) begin
      RESULT = 2'($urandom_range(0, 3));
      HP     = 2'($urandom_range(0, 3));
      STATE  = 4'($urandom_range(0, 15));
      step();
    end
    chk("churn_rx_count", rx_hist.size(), 1);
    if (rx_hist.size() == 1) chk("churn_byte", rx_hist[0], 8'h96);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      RESULT = 2'($urandom_range(0, 3));
      HP     = 2'($urandom_range(0, 3));
      STATE  = 4'($urandom_range(0, 15));
      SEND   = ($urandom_range(0, 39) == 0);
      step();
    end
    SEND = 1'b0;
    wait_idle();
    chk("random_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
